band_gain_mixer: RTL

BAND_GAIN_MIXER -- requirements
Module: band_gain_mixer

---
 rtl/band_gain_mixer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/band_gain_mixer.sv
// band_gain_mixer: multi-band audio mixer with per-band gain ramping.
// One multiplier is time-shared across the bands: a transfer is followed by
// NUM_BANDS MAC cycles and one OUT cycle that registers the saturated result.
module band_gain_mixer #(
    parameter int AUDIO_WIDTH = 24,
    parameter int GAIN_WIDTH  = 8,
    parameter int NUM_BANDS   = 10,
    parameter int OUT_SHIFT   = GAIN_WIDTH + 3,
    parameter int RAMP_STEP   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_BANDS*AUDIO_WIDTH-1:0]  bands_in,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_BANDS*GAIN_WIDTH-1:0]   gains_in,
    input  logic                              gain_load,
    output logic signed [AUDIO_WIDTH-1:0]     audio_out,
    output logic                              out_valid,
    output logic                              sat_flag
);
    localparam int IDX_W  = $clog2(NUM_BANDS);
    localparam int PROD_W = AUDIO_WIDTH + GAIN_WIDTH + 1;
    localparam int ACC_W  = PROD_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t state_q, state_d;

    logic [NUM_BANDS-1:0][AUDIO_WIDTH-1:0] band_set, band_q;
    logic [NUM_BANDS-1:0][GAIN_WIDTH-1:0]  gain_set, gain_tgt, gain_act;
    logic [IDX_W-1:0]                      idx;
    logic signed [ACC_W-1:0]               acc, acc_sh;
    logic signed [PROD_W-1:0]              band_ext, gain_ext, prod;
    logic [AUDIO_WIDTH-1:0]                band_cur;
    logic [GAIN_WIDTH-1:0]                 gain_cur;
    logic [ACC_W-AUDIO_WIDTH:0]            acc_top;
    logic                                  clip;
    logic [AUDIO_WIDTH-1:0]                sat_val;

    assign band_set = bands_in;
    assign gain_set = gains_in;
    assign in_ready = (state_q == S_IDLE);

    // Single shared multiplier: band is signed, gain is zero-extended so the
    // product is always a signed multiply.
    assign band_cur = band_q[idx];
    assign gain_cur = gain_act[idx];
    assign band_ext = {{(GAIN_WIDTH+1){band_cur[AUDIO_WIDTH-1]}}, band_cur};
    assign gain_ext = {{(AUDIO_WIDTH+1){1'b0}}, gain_cur};
    assign prod     = band_ext * gain_ext;

    // Clip whenever the bits above the output sign bit disagree with it.
    assign acc_sh  = acc >>> OUT_SHIFT;
    assign acc_top = acc_sh[ACC_W-1:AUDIO_WIDTH-1];
    assign clip    = !((&acc_top) || !(|acc_top));
    assign sat_val = acc_sh[ACC_W-1] ? {1'b1, {(AUDIO_WIDTH-1){1'b0}}}
                                     : {1'b0, {(AUDIO_WIDTH-1){1'b1}}};

    // Step a gain toward its target, snapping when within one step.
    function automatic logic [GAIN_WIDTH-1:0] ramp_to(input logic [GAIN_WIDTH-1:0] cur,
                                                     input logic [GAIN_WIDTH-1:0] tgt);
        logic [GAIN_WIDTH:0]   step;
        logic [GAIN_WIDTH:0]   diff;
        logic [GAIN_WIDTH-1:0] res;
        step = (GAIN_WIDTH+1)'(RAMP_STEP);
        res  = tgt;
        if (RAMP_STEP != 0) begin
            if (tgt >= cur) begin
                diff = {1'b0, tgt} - {1'b0, cur};
                if (diff > step) res = cur + step[GAIN_WIDTH-1:0];
            end else begin
                diff = {1'b0, cur} - {1'b0, tgt};
                if (diff > step) res = cur - step[GAIN_WIDTH-1:0];
            end
        end
        return res;
    endfunction

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: IDLE -> MAC (NUM_BANDS cycles) -> OUT -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_MAC;
            S_MAC:   if (idx == LAST_IDX) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sample capture and accumulation, one band per MAC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            band_q <= '0;
            acc    <= '0;
            idx    <= '0;
        end else if (state_q == S_IDLE && in_valid) begin
            band_q <= band_set;
            acc    <= '0;
            idx    <= '0;
        end else if (state_q == S_MAC) begin
            acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            idx <= idx + 1'b1;
        end
    end

    // Registered output; audio_out holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_out <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= (state_q == S_OUT);
            sat_flag  <= (state_q == S_OUT) && clip;
            if (state_q == S_OUT)
                audio_out <= clip ? sat_val : acc_sh[AUDIO_WIDTH-1:0];
        end
    end

    // Targets load any time; active gains ramp only at the end of OUT, so a
    // load coinciding with OUT ramps toward the old target this time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_tgt <= '0;
            gain_act <= '0;
        end else begin
            if (gain_load) gain_tgt <= gain_set;
            if (state_q == S_OUT) begin
                for (int k = 0; k < NUM_BANDS; k++)
                    gain_act[k] <= ramp_to(gain_act[k], gain_tgt[k]);
            end
        end
    end

endmodule
